// File: rtl/seg_display_sequencer.sv
// Single-digit 7-segment sequencer: steps a digit index through 0..L at a
// programmable dwell rate under run/pause/step/stop command strobes.
module seg_display_sequencer #(
  parameter int unsigned DWELL_W       = 8,
  parameter logic [3:0]  DEFAULT_LIMIT = 4'hF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  input  logic               STEP,
  input  logic               DIR,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic               LIMIT_OVR,
  input  logic [3:0]         LIMIT,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               D,
  output logic               E,
  output logic               F,
  output logic               G,
  output logic               DP,
  output logic               BUSY,
  output logic               WRAP
);

  localparam int unsigned DigitW = 4;
  localparam int unsigned SegW   = 7;

  typedef enum logic [1:0] {
    stIdle  = 2'd0,
    stRun   = 2'd1,
    stPause = 2'd2
  } stateT;

  stateT              state;
  logic [DigitW-1:0]  digit;
  logic [DWELL_W-1:0] presc;
  logic [SegW-1:0]    segReg;
  logic               dpReg;
  logic               busyReg;
  logic               wrapReg;

  logic [DigitW-1:0]  effLimit;
  logic [DigitW-1:0]  stepDigit;
  logic               stepWrap;

  // Segment pattern {G,F,E,D,C,B,A} for a hex digit.
  function automatic logic [SegW-1:0] decode(input logic [DigitW-1:0] d);
    logic [SegW-1:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next digit and wrap flag if a step were taken this cycle.
  always_comb begin
    effLimit  = LIMIT_OVR ? LIMIT : DEFAULT_LIMIT;
    stepDigit = digit;
    stepWrap  = 1'b0;
    if (!DIR) begin
      if (digit >= effLimit) begin
        stepDigit = '0;
        stepWrap  = 1'b1;
      end else begin
        stepDigit = digit + DigitW'(1);
      end
    end else begin
      // An index above a freshly lowered limit also wraps to the limit.
      if ((digit == '0) || (digit > effLimit)) begin
        stepDigit = effLimit;
        stepWrap  = 1'b1;
      end else begin
        stepDigit = digit - DigitW'(1);
      end
    end
  end

  // Command FSM with dwell prescaler; every output is a register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= stIdle;
      digit   <= '0;
      presc   <= '0;
      segReg  <= '0;
      dpReg   <= 1'b0;
      busyReg <= 1'b0;
      wrapReg <= 1'b0;
    end else begin
      wrapReg <= 1'b0;
      case (state)
        stIdle: begin
          if (START) begin
            state   <= stRun;
            busyReg <= 1'b1;
            segReg  <= decode(digit);
          end
        end
        stRun: begin
          // STOP beats a coincident dwell tick; presc is held for resume.
          if (STOP) begin
            state   <= stPause;
            busyReg <= 1'b0;
          end else if (presc >= DWELL) begin
            presc   <= '0;
            digit   <= stepDigit;
            segReg  <= decode(stepDigit);
            dpReg   <= ~dpReg;
            wrapReg <= stepWrap;
          end else begin
            presc <= presc + DWELL_W'(1);
          end
        end
        stPause: begin
          if (STOP) begin
            state   <= stIdle;
            digit   <= '0;
            presc   <= '0;
            segReg  <= '0;
            dpReg   <= 1'b0;
            busyReg <= 1'b0;
          end else if (START) begin
            state   <= stRun;
            busyReg <= 1'b1;
          end else if (STEP) begin
            presc   <= '0;
            digit   <= stepDigit;
            segReg  <= decode(stepDigit);
            dpReg   <= ~dpReg;
            wrapReg <= stepWrap;
          end
        end
        default: begin
          state   <= stIdle;
          digit   <= '0;
          presc   <= '0;
          segReg  <= '0;
          dpReg   <= 1'b0;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign {G, F, E, D, C, B, A} = segReg;
  assign DP   = dpReg;
  assign BUSY = busyReg;
  assign WRAP = wrapReg;

endmodule
